zoom_scan_sequencer: RTL

ZOOM_SCAN_SEQUENCER -- requirements
Module: zoom_scan_sequencer

---
 rtl/zoom_scan_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/zoom_scan_sequencer.sv
// zoom_scan_sequencer
//
// Walks a destination raster of the latched size (W x H) one pixel at a time
// and presents, for every destination pixel, the matching source pixel of the
// selected zoom ratio. It is a three-state FSM: IDLE, SCAN and FINISH.
//
// Handshake: in SCAN, PIX_VALID is 1 and DST_X/DST_Y/SRC_X/SRC_Y hold their
// values until a cycle in which PIX_VALID=1 and MEM_READY=1. That cycle is
// the acceptance, and the next coordinate appears after the following edge.
// ABORT in SCAN takes precedence over MEM_READY in the same cycle.
//
// Optional feature: define ZOOM_SEQ_FRAME_COUNT_EN to build the 8-bit
// completed-frame counter. Without the macro, FRAME_CNT is tied to 0.
//
// Ports:
//   CLK            in   1   sole clock, rising edge
//   RESET          in   1   asynchronous, active-high reset
//   START          in   1   frame start request, sampled only in IDLE
//   ABORT          in   1   cancels the frame in progress (SCAN only)
//   ALGORITHM      in   2   zoom algorithm select (0 NN, 1 PR, 2 DC, 3 BA)
//   IMG_WIDTH_IN   in  10   destination width W
//   IMG_HEIGHT_IN  in   9   destination height H
//   MEM_READY      in   1   datapath accepts the current pixel
//   PIX_VALID      out  1   coordinates valid (state SCAN)
//   DST_X, DST_Y   out 10/9 destination pixel coordinate
//   SRC_X, SRC_Y   out 10/9 source pixel coordinate, same cycle as DST
//   ALG_LATCHED    out  2   algorithm frozen at frame start
//   BUSY           out  1   1 in SCAN and FINISH
//   DONE           out  1   one-cycle pulse in FINISH
//   FRAME_CNT      out  8   completed frames, wraps 255 -> 0
//   STATE_DBG      out  2   current FSM state (0 IDLE, 1 SCAN, 2 FINISH)
module zoom_scan_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic [1:0] ALGORITHM,
    input  logic [9:0] IMG_WIDTH_IN,
    input  logic [8:0] IMG_HEIGHT_IN,
    input  logic       MEM_READY,
    output logic       PIX_VALID,
    output logic [9:0] DST_X,
    output logic [8:0] DST_Y,
    output logic [9:0] SRC_X,
    output logic [8:0] SRC_Y,
    output logic [1:0] ALG_LATCHED,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] FRAME_CNT,
    output logic [1:0] STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] w_q, w_d;
    logic [8:0] h_q, h_d;
    logic [1:0] alg_q, alg_d;
    logic [9:0] dst_x_q, dst_x_d;
    logic [8:0] dst_y_q, dst_y_d;
    logic [9:0] src_x_q, src_x_d;
    logic [8:0] src_y_q, src_y_d;

    // Source mapping is selected by the latched width alone and applies to
    // both axes: 320 wide is a 2x upscale, 80 wide is a 2x downscale.
    function automatic logic [9:0] map_x(input logic [9:0] w, input logic [9:0] d);
        if (w == 10'd320)     return d >> 1;
        else if (w == 10'd80) return d << 1;
        else                  return d;
    endfunction

    function automatic logic [8:0] map_y(input logic [9:0] w, input logic [8:0] d);
        if (w == 10'd320)     return d >> 1;
        else if (w == 10'd80) return d << 1;
        else                  return d;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            alg_q   <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            src_x_q <= '0;
            src_y_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            alg_q   <= alg_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        alg_d   = alg_q;
        dst_x_d = dst_x_q;
        dst_y_d = dst_y_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    w_d     = IMG_WIDTH_IN;
                    h_d     = IMG_HEIGHT_IN;
                    alg_d   = ALGORITHM;
                    dst_x_d = '0;
                    dst_y_d = '0;
                    src_x_d = '0;
                    src_y_d = '0;
                    // An empty frame has no pixels to present: go straight to FINISH.
                    if (IMG_WIDTH_IN == 10'd0 || IMG_HEIGHT_IN == 9'd0)
                        state_d = S_FINISH;
                    else
                        state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (MEM_READY) begin
                    if (dst_x_q == w_q - 10'd1) begin
                        if (dst_y_q == h_q - 9'd1) begin
                            // Last pixel accepted; coordinates are left as-is.
                            state_d = S_FINISH;
                        end else begin
                            dst_x_d = '0;
                            dst_y_d = dst_y_q + 9'd1;
                        end
                    end else begin
                        dst_x_d = dst_x_q + 10'd1;
                    end
                    // Source registers load from the next destination value so
                    // both pairs change on the same edge.
                    src_x_d = map_x(w_q, dst_x_d);
                    src_y_d = map_y(w_q, dst_y_d);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign PIX_VALID   = (state_q == S_SCAN);
    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = (state_q == S_FINISH);
    assign DST_X       = dst_x_q;
    assign DST_Y       = dst_y_q;
    assign SRC_X       = src_x_q;
    assign SRC_Y       = src_y_q;
    assign ALG_LATCHED = alg_q;
    assign STATE_DBG   = state_q;

`ifdef ZOOM_SEQ_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            frame_cnt_q <= '0;
        else if (state_q == S_FINISH)
            frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign FRAME_CNT = frame_cnt_q;
`else
    assign FRAME_CNT = 8'd0;
`endif

endmodule
